// File: rtl/alu_pkg.sv
// Shared definitions for the locked ALU pool.
// - word_t   : 32-bit ALU data word
// - FUNCT_*  : MIPS R-type funct codes understood by alu_core
// Shift codes are only executed when ALU_SHIFT_OPS_EN is defined.
package alu_pkg;

  typedef logic [31:0] word_t;

  localparam logic [5:0] FUNCT_SLL  = 6'h00;
  localparam logic [5:0] FUNCT_SRL  = 6'h02;
  localparam logic [5:0] FUNCT_SRA  = 6'h03;
  localparam logic [5:0] FUNCT_SLLV = 6'h04;
  localparam logic [5:0] FUNCT_SRLV = 6'h06;
  localparam logic [5:0] FUNCT_SRAV = 6'h07;
  localparam logic [5:0] FUNCT_ADD  = 6'h20;
  localparam logic [5:0] FUNCT_ADDU = 6'h21;
  localparam logic [5:0] FUNCT_SUB  = 6'h22;
  localparam logic [5:0] FUNCT_SUBU = 6'h23;
  localparam logic [5:0] FUNCT_AND  = 6'h24;
  localparam logic [5:0] FUNCT_OR   = 6'h25;
  localparam logic [5:0] FUNCT_XOR  = 6'h26;
  localparam logic [5:0] FUNCT_NOR  = 6'h27;
  localparam logic [5:0] FUNCT_SLT  = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU = 6'h2B;

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit integer ALU (MIPS R-type funct subset).
// Ports:
//   a_i     in  32  operand A (shift amount source, a_i[4:0], for shifts)
//   b_i     in  32  operand B (value shifted for shifts)
//   funct_i in  6   funct code
//   res_o   out 32  result; unknown codes give 0
// Configuration: ALU_SHIFT_OPS_EN enables sll/srl/sra/sllv/srlv/srav.
module alu_core
  import alu_pkg::*;
(
  input  word_t      a_i,
  input  word_t      b_i,
  input  logic [5:0] funct_i,
  output word_t      res_o
);

  always_comb begin
    res_o = '0;
    case (funct_i)
      FUNCT_ADD, FUNCT_ADDU: res_o = a_i + b_i;
      FUNCT_SUB, FUNCT_SUBU: res_o = a_i - b_i;
      FUNCT_AND:             res_o = a_i & b_i;
      FUNCT_OR:              res_o = a_i | b_i;
      FUNCT_XOR:             res_o = a_i ^ b_i;
      FUNCT_NOR:             res_o = ~(a_i | b_i);
      FUNCT_SLT:             res_o = {31'b0, ($signed(a_i) < $signed(b_i))};
      FUNCT_SLTU:            res_o = {31'b0, (a_i < b_i)};
`ifdef ALU_SHIFT_OPS_EN
      // Fixed and variable shifts both take the amount from a_i[4:0].
      FUNCT_SLL, FUNCT_SLLV: res_o = b_i << a_i[4:0];
      FUNCT_SRL, FUNCT_SRLV: res_o = b_i >> a_i[4:0];
      FUNCT_SRA, FUNCT_SRAV: res_o = word_t'($signed(b_i) >>> a_i[4:0]);
`endif
      default:               res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_array_locked.sv
// Pool of NUM_ALUS ALUs shared by NUM_PORTS issue channels with per-ALU locks.
// A free ALU is flash-granted (same cycle) to the requester with the smallest
// issue ID (lowest port index on ties) and stays locked to that owner until
// the owner asserts sic_release.
// Ports (arrays are [NUM_PORTS]):
//   clk, rst       clock, synchronous active-high reset
//   sic_alu_id     target ALU per channel (>= NUM_ALUS never granted)
//   sic_req        channel requests its target ALU
//   sic_issue_id   priority tag, smaller = older = higher priority
//   sic_release    owner frees its ALU at the next rising edge
//   sic_op_a/b     operands; sic_op_code funct code
//   sic_res_out    ALU result when granted, else 0
//   sic_grant_out  channel owns or flash-wins its target ALU
// Configuration: ALU_SHIFT_OPS_EN (in alu_core) adds shift funct codes.
module alu_array_locked
  import alu_pkg::*;
#(
  parameter int unsigned NUM_ALUS  = 2,
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ID_WIDTH  = 8,
  parameter int unsigned ALU_ID_W  = (NUM_ALUS > 1) ? $clog2(NUM_ALUS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ALU_ID_W-1:0] sic_alu_id    [NUM_PORTS],
  input  logic                sic_req       [NUM_PORTS],
  input  logic [ID_WIDTH-1:0] sic_issue_id  [NUM_PORTS],
  input  logic                sic_release   [NUM_PORTS],
  input  logic [31:0]         sic_op_a      [NUM_PORTS],
  input  logic [31:0]         sic_op_b      [NUM_PORTS],
  input  logic [5:0]          sic_op_code   [NUM_PORTS],
  output logic [31:0]         sic_res_out   [NUM_PORTS],
  output logic                sic_grant_out [NUM_PORTS]
);

  localparam int unsigned PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_ALUS-1:0]  locked_q, locked_d;
  logic [PORT_W-1:0]    owner_q [NUM_ALUS];
  logic [PORT_W-1:0]    owner_d [NUM_ALUS];

  logic [NUM_ALUS-1:0]  win_vld;
  logic [PORT_W-1:0]    win_idx [NUM_ALUS];
  logic [ID_WIDTH-1:0]  win_id  [NUM_ALUS];
  logic [NUM_ALUS-1:0]  owner_rel;
  logic [NUM_PORTS-1:0] grant;
  word_t                core_res [NUM_PORTS];

  // Min-ID search per ALU. Ports are scanned in ascending order with a strict
  // compare, so the lowest port index keeps the win on equal IDs.
  always_comb begin
    win_vld = '0;
    for (int unsigned k = 0; k < NUM_ALUS; k++) begin
      win_idx[k] = '0;
      win_id[k]  = '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (sic_req[p] && (sic_alu_id[p] == ALU_ID_W'(k))) begin
          if (!win_vld[k] || (sic_issue_id[p] < win_id[k])) begin
            win_vld[k] = 1'b1;
            win_id[k]  = sic_issue_id[p];
            win_idx[k] = PORT_W'(p);
          end
        end
      end
    end
  end

  // Only the recorded owner can release; release on a free lock is ignored
  // because owner_rel is only consulted while locked.
  always_comb begin
    owner_rel = '0;
    for (int unsigned k = 0; k < NUM_ALUS; k++) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if ((owner_q[k] == PORT_W'(p)) && sic_release[p]) begin
          owner_rel[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    locked_d = locked_q;
    for (int unsigned k = 0; k < NUM_ALUS; k++) begin
      owner_d[k] = owner_q[k];
      if (locked_q[k]) begin
        if (owner_rel[k]) begin
          locked_d[k] = 1'b0;
        end
      end else if (win_vld[k]) begin
        locked_d[k] = 1'b1;
        owner_d[k]  = win_idx[k];
      end
    end
  end

  // A held lock grants its owner irrespective of sic_req; a free lock grants
  // the current winner. Out-of-range targets match no k and stay ungranted.
  always_comb begin
    grant = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      for (int unsigned k = 0; k < NUM_ALUS; k++) begin
        if (!rst && (sic_alu_id[p] == ALU_ID_W'(k))) begin
          if (locked_q[k]) begin
            grant[p] = (owner_q[k] == PORT_W'(p));
          end else begin
            grant[p] = win_vld[k] && (win_idx[k] == PORT_W'(p));
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      locked_q <= '0;
      for (int unsigned k = 0; k < NUM_ALUS; k++) begin
        owner_q[k] <= '0;
      end
    end else begin
      locked_q <= locked_d;
      for (int unsigned k = 0; k < NUM_ALUS; k++) begin
        owner_q[k] <= owner_d[k];
      end
    end
  end

  // One ALU datapath per channel: the result always follows the granted
  // channel's own operands.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    alu_core u_core (
      .a_i     (sic_op_a[p]),
      .b_i     (sic_op_b[p]),
      .funct_i (sic_op_code[p]),
      .res_o   (core_res[p])
    );
    assign sic_grant_out[p] = grant[p];
    assign sic_res_out[p]   = grant[p] ? core_res[p] : '0;
  end

endmodule

// File: tb/tb_alu_array_locked.sv
// Self-checking bench for alu_array_locked: directed scenarios followed by
// randomized traffic, all compared against a lock/arbitration model.
// Built with NUM_ALUS=3 so that target index 3 is out of range.
// Honors ALU_SHIFT_OPS_EN in its reference ALU.
module tb_alu_array_locked;

  localparam int NA  = 3;
  localparam int NP  = 4;
  localparam int IDW = 8;
  localparam int AW  = 2;

  logic           clk;
  logic           rst;
  logic [AW-1:0]  sic_alu_id    [NP];
  logic           sic_req       [NP];
  logic [IDW-1:0] sic_issue_id  [NP];
  logic           sic_release   [NP];
  logic [31:0]    sic_op_a      [NP];
  logic [31:0]    sic_op_b      [NP];
  logic [5:0]     sic_op_code   [NP];
  logic [31:0]    sic_res_out   [NP];
  logic           sic_grant_out [NP];

  alu_array_locked #(
    .NUM_ALUS  (NA),
    .NUM_PORTS (NP),
    .ID_WIDTH  (IDW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sic_alu_id    (sic_alu_id),
    .sic_req       (sic_req),
    .sic_issue_id  (sic_issue_id),
    .sic_release   (sic_release),
    .sic_op_a      (sic_op_a),
    .sic_op_b      (sic_op_b),
    .sic_op_code   (sic_op_code),
    .sic_res_out   (sic_res_out),
    .sic_grant_out (sic_grant_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Model state: which ALUs are held and by whom.
  bit          m_locked [NA];
  int          m_owner  [NA];

  logic [NP-1:0] obs_gnt;
  logic [31:0]   obs_res [NP];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [5:0] f);
    logic [4:0] sh;
    sh = a[4:0];
    case (f)
      6'h20, 6'h21: return a + b;
      6'h22, 6'h23: return a - b;
      6'h24: return a & b;
      6'h25: return a | b;
      6'h26: return a ^ b;
      6'h27: return ~(a | b);
      6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h2B: return (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_SHIFT_OPS_EN
      6'h00, 6'h04: return b << sh;
      6'h02, 6'h06: return b >> sh;
      6'h03, 6'h07: return $unsigned($signed(b) >>> sh);
`endif
      default: return 32'd0;
    endcase
  endfunction

  // Port p is the winner for ALU k if it requests k and no other requester
  // of k is strictly older, or equally old with a smaller port index.
  function automatic bit wins(input int p, input int k);
    if (!sic_req[p] || int'(sic_alu_id[p]) != k) return 1'b0;
    for (int q = 0; q < NP; q++) begin
      if (q != p && sic_req[q] && int'(sic_alu_id[q]) == k) begin
        if (sic_issue_id[q] < sic_issue_id[p]) return 1'b0;
        if (sic_issue_id[q] == sic_issue_id[p] && q < p) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  function automatic bit model_grant(input int p);
    int k;
    k = int'(sic_alu_id[p]);
    if (rst || k >= NA) return 1'b0;
    if (m_locked[k]) return (m_owner[k] == p);
    return wins(p, k);
  endfunction

  task automatic model_update();
    for (int k = 0; k < NA; k++) begin
      if (rst) begin
        m_locked[k] = 1'b0;
      end else if (m_locked[k]) begin
        if (sic_release[m_owner[k]]) m_locked[k] = 1'b0;
      end else begin
        for (int p = 0; p < NP; p++) begin
          if (wins(p, k)) begin
            m_locked[k] = 1'b1;
            m_owner[k]  = p;
          end
        end
      end
    end
  endtask

  // Inputs are stable from just after the posedge; outputs are sampled and
  // checked on the negedge, then the model advances on the posedge.
  task automatic tick();
    bit eg;
    @(negedge clk);
    for (int p = 0; p < NP; p++) begin
      eg = model_grant(p);
      obs_gnt[p] = sic_grant_out[p];
      obs_res[p] = sic_res_out[p];
      check($sformatf("gnt%0d", p), {31'b0, sic_grant_out[p]}, {31'b0, eg});
      check($sformatf("res%0d", p), sic_res_out[p],
            eg ? alu_ref(sic_op_a[p], sic_op_b[p], sic_op_code[p]) : 32'd0);
    end
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    for (int p = 0; p < NP; p++) begin
      sic_alu_id[p]   = '0;
      sic_req[p]      = 1'b0;
      sic_issue_id[p] = '0;
      sic_release[p]  = 1'b0;
      sic_op_a[p]     = '0;
      sic_op_b[p]     = '0;
      sic_op_code[p]  = '0;
    end
  endtask

  task automatic set_port(input int p, input int alu, input int id,
                          input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    sic_req[p]      = 1'b1;
    sic_alu_id[p]   = AW'(alu);
    sic_issue_id[p] = IDW'(id);
    sic_op_a[p]     = a;
    sic_op_b[p]     = b;
    sic_op_code[p]  = f;
  endtask

  function automatic logic [5:0] rand_op();
    case ($urandom_range(0, 17))
      0: return 6'h20;  1: return 6'h21;  2: return 6'h22;  3: return 6'h23;
      4: return 6'h24;  5: return 6'h25;  6: return 6'h26;  7: return 6'h27;
      8: return 6'h2A;  9: return 6'h2B; 10: return 6'h00; 11: return 6'h02;
      12: return 6'h03; 13: return 6'h04; 14: return 6'h06; 15: return 6'h07;
      16: return 6'h01;
      default: return 6'h3F;
    endcase
  endfunction

  initial begin
    for (int k = 0; k < NA; k++) begin
      m_locked[k] = 1'b0;
      m_owner[k]  = 0;
    end
    idle();
    rst = 1'b1;
    // Requests during reset must not be granted.
    set_port(0, 0, 1, 32'd3, 32'd4, 6'h20);
    tick();
    check("rst_gnt", {28'b0, obs_gnt}, 32'h0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    // Flash grant: port1 (id10) beats port0 (id20) on ALU0; port2 owns ALU1.
    set_port(0, 0, 20, 32'd1, 32'd1, 6'h20);
    set_port(1, 0, 10, 32'd2, 32'd2, 6'h20);
    set_port(2, 1, 30, 32'd10, 32'd5, 6'h22);
    tick();
    check("s1_gnt", {28'b0, obs_gnt}, 32'h6);
    check("s1_res1", obs_res[1], 32'd4);
    check("s1_res2", obs_res[2], 32'd5);
    check("s1_res0", obs_res[0], 32'd0);
    sic_release[1] = 1'b1;
    tick();
    check("s1_relcyc_gnt1", {31'b0, obs_gnt[1]}, 32'd1);
    check("s1_relcyc_gnt0", {31'b0, obs_gnt[0]}, 32'd0);
    sic_release[1] = 1'b0;
    sic_req[1]     = 1'b0;
    tick();
    check("s1_after_gnt0", {31'b0, obs_gnt[0]}, 32'd1);
    check("s1_after_res0", obs_res[0], 32'd2);
    idle();
    sic_release[0] = 1'b1;
    sic_release[2] = 1'b1;
    tick();
    idle();
    tick();

    // Held lock ignores an older requester until released.
    set_port(0, 0, 50, 32'd7, 32'd8, 6'h25);
    tick();
    set_port(3, 0, 5, 32'd1, 32'd2, 6'h20);
    tick();
    check("s2_hold_gnt", {28'b0, obs_gnt}, 32'h1);
    tick();
    check("s2_hold2_gnt", {28'b0, obs_gnt}, 32'h1);
    sic_release[0] = 1'b1;
    tick();
    check("s2_rel_gnt", {28'b0, obs_gnt}, 32'h1);
    sic_release[0] = 1'b0;
    sic_req[0]     = 1'b0;
    tick();
    check("s2_new_gnt", {28'b0, obs_gnt}, 32'h8);
    check("s2_new_res", obs_res[3], 32'd3);
    idle();
    sic_release[3] = 1'b1;
    tick();
    idle();
    tick();

    // Equal issue IDs: lower port index wins.
    set_port(2, 1, 7, 32'd1, 32'd1, 6'h20);
    set_port(3, 1, 7, 32'd1, 32'd1, 6'h20);
    tick();
    check("s3_tie_gnt", {28'b0, obs_gnt}, 32'h4);
    idle();
    sic_release[2] = 1'b1;
    tick();
    idle();
    tick();

    // Reset while locks are held, then re-arbitration.
    set_port(1, 0, 9, 32'd1, 32'd1, 6'h20);
    set_port(0, 1, 3, 32'd1, 32'd1, 6'h20);
    tick();
    set_port(2, 0, 1, 32'd5, 32'd6, 6'h24);
    tick();
    check("s4_held_gnt", {28'b0, obs_gnt}, 32'h3);
    rst = 1'b1;
    tick();
    check("s4_rst_gnt", {28'b0, obs_gnt}, 32'h0);
    check("s4_rst_res1", obs_res[1], 32'd0);
    rst = 1'b0;
    tick();
    check("s4_post_gnt", {28'b0, obs_gnt}, 32'h5);
    check("s4_post_res2", obs_res[2], 32'd4);
    idle();
    sic_release[0] = 1'b1;
    sic_release[2] = 1'b1;
    tick();
    idle();
    tick();

    // Out-of-range target index.
    set_port(3, 3, 0, 32'd1, 32'd1, 6'h20);
    tick();
    check("s5_bad_alu", {31'b0, obs_gnt[3]}, 32'd0);
    idle();

    // Compare and shift op codes on a held ALU.
    set_port(0, 0, 0, 32'hFFFF_FFFF, 32'd1, 6'h2A);
    tick();
    check("op_slt", obs_res[0], 32'd1);
    sic_op_code[0] = 6'h2B;
    tick();
    check("op_sltu", obs_res[0], 32'd0);
    sic_op_a[0]    = 32'd4;
    sic_op_code[0] = 6'h00;
    tick();
`ifdef ALU_SHIFT_OPS_EN
    check("op_sll", obs_res[0], 32'd16);
`else
    check("op_sll", obs_res[0], 32'd0);
`endif
    idle();
    sic_release[0] = 1'b1;
    tick();
    idle();
    tick();

    // Randomized traffic.
    for (int c = 0; c < 800; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int p = 0; p < NP; p++) begin
        sic_req[p]      = ($urandom_range(0, 3) != 0);
        sic_alu_id[p]   = AW'($urandom_range(0, 3));
        sic_issue_id[p] = IDW'($urandom_range(0, 15));
        sic_release[p]  = ($urandom_range(0, 3) == 0);
        sic_op_a[p]     = $urandom;
        sic_op_b[p]     = $urandom;
        sic_op_code[p]  = rand_op();
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
